// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: pad synchroniser, programmable debounce, edge-qualified interrupt.
// Optional ECNT qualifying-edge counter at offset 0xC when GPIO_IN_FILTER_EDGE_COUNT_EN is defined.
module gpio_in_filter #(
    parameter int CNT_W   = 16,
    parameter int THR_RST = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        pad_in,
    output logic        filt,
    output logic        irq
);

    localparam logic [CNT_W-1:0] THR_RST_V = CNT_W'(THR_RST);

    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             s1_q, s2_q;
    logic             filt_q, filt_d;
    logic             filt_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic [1:0]       edge_sel_q, edge_sel_d;
    logic             ie_q, ie_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic             pend_q, pend_d;

    logic             accept_s, wr_s;
    logic [1:0]       sel_s;
    logic [CNT_W-1:0] thr_eff_s;
    logic [CNT_W:0]   cnt_inc_s;
    logic             qual_s;
    logic [31:0]      thr_wr_s;
    logic             unused_s;

`ifdef GPIO_IN_FILTER_EDGE_COUNT_EN
    logic [31:0]      ecnt_q, ecnt_d;
`endif

    assign unused_s = ^{addr[31:4], addr[1:0]};

    // Bus decode and effective debounce threshold
    always_comb begin
        accept_s  = valid && !ready_q;
        wr_s      = accept_s && (wstrb != 4'b0000);
        sel_s     = addr[3:2];
        thr_eff_s = (!en_q || (thr_q == '0)) ? CNT_W'(1) : thr_q;
        cnt_inc_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        qual_s    = ((filt_q && !filt_prev_q) && edge_sel_q[0]) ||
                    ((!filt_q && filt_prev_q) && edge_sel_q[1]);
    end

    // Debounce: filt follows s2 only after it has differed for T consecutive compares
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (s2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_inc_s >= {1'b0, thr_eff_s}) begin
            filt_d = s2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_inc_s[CNT_W-1:0];
        end
    end

    // Register writes; a pending-edge set overrides a same-cycle W1C
    always_comb begin
        en_d       = en_q;
        edge_sel_d = edge_sel_q;
        ie_d       = ie_q;
        thr_d      = thr_q;
        pend_d     = pend_q;
        thr_wr_s   = 32'(thr_q);
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                thr_wr_s[8*i +: 8] = wdata[8*i +: 8];
            end else begin
                thr_wr_s[8*i +: 8] = thr_wr_s[8*i +: 8];
            end
        end
        if (wr_s) begin
            case (sel_s)
                2'b00: begin
                    if (wstrb[0]) begin
                        en_d       = wdata[0];
                        edge_sel_d = wdata[2:1];
                        ie_d       = wdata[3];
                    end else begin
                        en_d = en_q;
                    end
                end
                2'b01: thr_d = thr_wr_s[CNT_W-1:0];
                2'b10: begin
                    if (wstrb[0] && wdata[1]) begin
                        pend_d = 1'b0;
                    end else begin
                        pend_d = pend_q;
                    end
                end
                default: pend_d = pend_q;
            endcase
        end else begin
            pend_d = pend_q;
        end
        if (qual_s) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_d;
        end
    end

`ifdef GPIO_IN_FILTER_EDGE_COUNT_EN
    // Qualifying-edge counter; a write clears it even when an edge lands the same cycle
    always_comb begin
        ecnt_d = ecnt_q + (qual_s ? 32'd1 : 32'd0);
        if (wr_s && (sel_s == 2'b11)) begin
            ecnt_d = 32'd0;
        end else begin
            ecnt_d = ecnt_d;
        end
    end
`endif

    // Read mux and one-cycle ready pulse; rdata holds when no access is accepted
    always_comb begin
        ready_d = accept_s;
        rdata_d = rdata_q;
        if (accept_s) begin
            case (sel_s)
                2'b00:   rdata_d = {28'd0, ie_q, edge_sel_q, en_q};
                2'b01:   rdata_d = 32'(thr_q);
                2'b10:   rdata_d = {29'd0, s2_q, pend_q, filt_q};
`ifdef GPIO_IN_FILTER_EDGE_COUNT_EN
                2'b11:   rdata_d = ecnt_q;
`endif
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q     <= 1'b0;
            rdata_q     <= 32'd0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            edge_sel_q  <= 2'b00;
            ie_q        <= 1'b0;
            thr_q       <= THR_RST_V;
            pend_q      <= 1'b0;
`ifdef GPIO_IN_FILTER_EDGE_COUNT_EN
            ecnt_q      <= 32'd0;
`endif
        end else begin
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            s1_q        <= pad_in;
            s2_q        <= s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            edge_sel_q  <= edge_sel_d;
            ie_q        <= ie_d;
            thr_q       <= thr_d;
            pend_q      <= pend_d;
`ifdef GPIO_IN_FILTER_EDGE_COUNT_EN
            ecnt_q      <= ecnt_d;
`endif
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign filt  = filt_q;
    assign irq   = pend_q & ie_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed self-checking bench for gpio_in_filter (default CNT_W=16, THR_RST=16).
module tb_gpio_in_filter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        pad_in;
    logic        filt;
    logic        irq;

    int          checks_cnt = 0;
    int          errors_cnt = 0;
    logic [31:0] rd_v;
    logic        seen_hi_v;

    gpio_in_filter dut (
        .clk    (clk),
        .resetn (resetn),
        .valid  (valid),
        .ready  (ready),
        .wstrb  (wstrb),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .pad_in (pad_in),
        .filt   (filt),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance n clock edges and settle just after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus access; called 1 time unit after an edge, returns likewise
    task automatic bus(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] d,
                       output logic [31:0] r);
        valid = 1'b1;
        addr  = a;
        wstrb = ws;
        wdata = d;
        step(1);
        valid = 1'b0;
        wstrb = 4'b0000;
        check_eq("ready_high", {31'd0, ready}, 32'd1);
        r = rdata;
        step(1);
        check_eq("ready_low", {31'd0, ready}, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(a, 4'b0000, 32'd0, r);
        check_eq(tag, r, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] d);
        logic [31:0] r;
        bus(a, ws, d, r);
    endtask

    initial begin
        resetn = 1'b0;
        valid  = 1'b0;
        wstrb  = 4'b0000;
        addr   = 32'd0;
        wdata  = 32'd0;
        pad_in = 1'b0;
        step(3);
        check_eq("rst_ready", {31'd0, ready}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_filt", {31'd0, filt}, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        resetn = 1'b1;
        step(1);

        rd_chk("rst_ctrl", 32'h0, 32'h0);
        rd_chk("rst_thr", 32'h4, 32'h10);
        step(3);
        check_eq("rdata_hold", rdata, 32'h10);
        rd_chk("rst_status", 32'h8, 32'h0);

        // EN=0, EDGE=rise, IE=1: three-edge latency, irq one edge later
        wr(32'h0, 4'b0001, 32'hA);
        rd_chk("ctrl_rb", 32'h0, 32'hA);
        pad_in = 1'b1;
        step(2);
        check_eq("en0_filt_e2", {31'd0, filt}, 32'd0);
        step(1);
        check_eq("en0_filt_e3", {31'd0, filt}, 32'd1);
        check_eq("en0_irq_e3", {31'd0, irq}, 32'd0);
        step(1);
        check_eq("en0_irq_e4", {31'd0, irq}, 32'd1);
        rd_chk("status_pend", 32'h8, 32'h7);
        wr(32'h8, 4'b0001, 32'h2);
        check_eq("w1c_irq", {31'd0, irq}, 32'd0);
        rd_chk("status_clr", 32'h8, 32'h5);

        // Fall is not qualifying with EDGE=rise
        pad_in = 1'b0;
        step(6);
        check_eq("fall_noirq", {31'd0, irq}, 32'd0);
        rd_chk("status_nofall", 32'h8, 32'h0);

        // EN=1, THR=4 via lane 0 only: short pulse rejected, 4-cycle pulse passes
        wr(32'h0, 4'b0001, 32'hB);
        wr(32'h4, 4'b0001, 32'hFFFF_0304);
        rd_chk("thr_lane", 32'h4, 32'h4);
        pad_in = 1'b1;
        step(3);
        pad_in = 1'b0;
        seen_hi_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            seen_hi_v = seen_hi_v | filt;
        end
        check_eq("glitch_filt", {31'd0, seen_hi_v}, 32'd0);
        rd_chk("glitch_status", 32'h8, 32'h0);
        pad_in = 1'b1;
        step(4);
        pad_in = 1'b0;
        step(1);
        check_eq("thr4_filt_e5", {31'd0, filt}, 32'd0);
        step(1);
        check_eq("thr4_filt_e6", {31'd0, filt}, 32'd1);
        step(3);
        check_eq("thr4_filt_e9", {31'd0, filt}, 32'd1);
        check_eq("thr4_irq", {31'd0, irq}, 32'd1);
        step(1);
        check_eq("thr4_filt_e10", {31'd0, filt}, 32'd0);
        wr(32'h8, 4'b0001, 32'h2);

        // EDGE=fall, IE=0: PEND on the fall only, irq masked until IE set
        wr(32'h0, 4'b0001, 32'h4);
        pad_in = 1'b1;
        step(6);
        rd_chk("fall_rise_status", 32'h8, 32'h5);
        pad_in = 1'b0;
        step(6);
        rd_chk("fall_status", 32'h8, 32'h2);
        check_eq("fall_irq_masked", {31'd0, irq}, 32'd0);
        wr(32'h0, 4'b0001, 32'hC);
        check_eq("ie_set_irq", {31'd0, irq}, 32'd1);
        wr(32'h0, 4'b0001, 32'h4);
        check_eq("ie_clr_irq", {31'd0, irq}, 32'd0);
        rd_chk("ie_clr_pend", 32'h8, 32'h2);

        // W1C accepted on the very edge PEND gets set: set wins
        wr(32'h8, 4'b0001, 32'h2);
        wr(32'h0, 4'b0001, 32'h6);
        pad_in = 1'b1;
        step(3);
        check_eq("race_filt", {31'd0, filt}, 32'd1);
        wr(32'h8, 4'b0001, 32'h2);
        rd_chk("race_status", 32'h8, 32'h7);

        // THR=0 with EN=1 behaves like EN=0
        wr(32'h4, 4'b0001, 32'h0);
        rd_chk("thr_zero", 32'h4, 32'h0);
        wr(32'h0, 4'b0001, 32'h1);
        pad_in = 1'b0;
        step(2);
        check_eq("thr0_filt_e2", {31'd0, filt}, 32'd1);
        step(1);
        check_eq("thr0_filt_e3", {31'd0, filt}, 32'd0);

`ifdef GPIO_IN_FILTER_EDGE_COUNT_EN
        wr(32'h0, 4'b0001, 32'h6);
        wr(32'hC, 4'b1111, 32'h0);
        rd_chk("ecnt_clr0", 32'hC, 32'h0);
        for (int i = 0; i < 5; i++) begin
            pad_in = ~pad_in;
            step(6);
        end
        rd_chk("ecnt_five", 32'hC, 32'h5);
        wr(32'hC, 4'b0001, 32'h0);
        rd_chk("ecnt_clr", 32'hC, 32'h0);
        @(negedge clk);
        force dut.ecnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.ecnt_q;
        step(1);
        rd_chk("ecnt_max", 32'hC, 32'hFFFF_FFFF);
        pad_in = ~pad_in;
        step(6);
        rd_chk("ecnt_wrap", 32'hC, 32'h0);
`else
        rd_chk("ecnt_absent", 32'hC, 32'h0);
        wr(32'hC, 4'b1111, 32'hFFFF_FFFF);
        rd_chk("ecnt_absent_wr", 32'hC, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
